// File: rtl/vga_axil_slave_ctrl_if.sv
// AXI4-Lite bus bundle between a master and the VGA register/frame-memory slave controller.
interface vga_axil_slave_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/vga_axil_slave_ctrl.sv
// AXI4-Lite slave turning bus transactions into single-cycle native strobes.
// Optional native read timeout: define VGA_AXIL_SLAVE_CTRL_RD_TIMEOUT_EN.
//
// state       | meaning
// WR_IDLE     | waiting for AW and/or W
// WR_GOT_ADDR | AW latched, waiting for W
// WR_GOT_DATA | W latched, waiting for AW
// WR_COMMIT   | native write strobe (suppressed on range error or empty strobes)
// WR_RESP     | B response presented until bready
// RD_IDLE     | waiting for AR
// RD_REQ      | native read strobe
// RD_WAIT     | waiting for rd_valid_i (or timeout)
// RD_RESP     | R response presented until rready
module vga_axil_slave_ctrl #(
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int NUM_WORDS       = 1024,
    parameter int RD_TIMEOUT      = 16,
    localparam int STRB_W            = AXIL_DATA_WIDTH / 8,
    localparam int OFS               = $clog2(STRB_W),
    localparam int NATIVE_ADDR_WIDTH = AXIL_ADDR_WIDTH - OFS
) (
    input  logic                         clk,
    input  logic                         arst_n,
    vga_axil_slave_ctrl_if.slave         axil,
    output logic                         wr_en_o,
    output logic [NATIVE_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [AXIL_DATA_WIDTH-1:0]   wr_data_o,
    output logic [STRB_W-1:0]            wr_strb_o,
    output logic                         rd_en_o,
    output logic [NATIVE_ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [AXIL_DATA_WIDTH-1:0]   rd_data_i,
    input  logic                         rd_valid_i
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [NATIVE_ADDR_WIDTH:0] NUM_WORDS_L = (NATIVE_ADDR_WIDTH + 1)'(NUM_WORDS);

    if (AXIL_DATA_WIDTH != 32 && AXIL_DATA_WIDTH != 64) begin : g_bad_dw
        $error("vga_axil_slave_ctrl: AXIL_DATA_WIDTH must be 32 or 64");
    end
    if (RD_TIMEOUT < 2) begin : g_bad_tmo
        $error("vga_axil_slave_ctrl: RD_TIMEOUT must be >= 2");
    end

    typedef enum logic [2:0] {
        WR_IDLE, WR_GOT_ADDR, WR_GOT_DATA, WR_COMMIT, WR_RESP
    } wr_state_e;
    typedef enum logic [1:0] {
        RD_IDLE, RD_REQ, RD_WAIT, RD_RESP
    } rd_state_e;

    wr_state_e                    wr_state_q, wr_state_d;
    rd_state_e                    rd_state_q, rd_state_d;
    logic [NATIVE_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [AXIL_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [STRB_W-1:0]            wr_strb_q, wr_strb_d;
    logic                         wr_err_q, wr_err_d;
    logic [NATIVE_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [AXIL_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                   rresp_q, rresp_d;
    logic                         awready_q, awready_d;
    logic                         wready_q, wready_d;
    logic                         arready_q, arready_d;

    logic aw_hs, w_hs, ar_hs, aw_oor, ar_oor;
    logic unused_addr_lsbs;

    assign aw_hs  = axil.awvalid & awready_q;
    assign w_hs   = axil.wvalid & wready_q;
    assign ar_hs  = axil.arvalid & arready_q;
    assign aw_oor = {1'b0, axil.awaddr[AXIL_ADDR_WIDTH-1:OFS]} >= NUM_WORDS_L;
    assign ar_oor = {1'b0, axil.araddr[AXIL_ADDR_WIDTH-1:OFS]} >= NUM_WORDS_L;
    assign unused_addr_lsbs = ^{axil.awaddr[OFS-1:0], axil.araddr[OFS-1:0]};

`ifdef VGA_AXIL_SLAVE_CTRL_RD_TIMEOUT_EN
    localparam int TMR_W = $clog2(RD_TIMEOUT);
    logic [TMR_W-1:0] rd_tmr_q, rd_tmr_d;

    // Down-counter loaded on entry to RD_WAIT; terminal count means the target never answered.
    always_comb begin
        rd_tmr_d = rd_tmr_q;
        if (rd_state_q == RD_REQ) begin
            rd_tmr_d = TMR_W'(RD_TIMEOUT - 1);
        end else if (rd_state_q == RD_WAIT && rd_tmr_q != '0) begin
            rd_tmr_d = rd_tmr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rd_tmr_q <= '0;
        else         rd_tmr_q <= rd_tmr_d;
    end
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_err_q   <= 1'b0;
            rd_addr_q  <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            wr_err_q   <= wr_err_d;
            rd_addr_q  <= rd_addr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
        end
    end

    // Ready flops only open in states that can take the channel, so latches never clobber a pending write.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        wr_err_d   = wr_err_q;
        if (aw_hs) begin
            wr_addr_d = axil.awaddr[AXIL_ADDR_WIDTH-1:OFS];
            wr_err_d  = aw_oor;
        end
        if (w_hs) begin
            wr_data_d = axil.wdata;
            wr_strb_d = axil.wstrb;
        end
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_COMMIT;
                else if (aw_hs)    wr_state_d = WR_GOT_ADDR;
                else if (w_hs)     wr_state_d = WR_GOT_DATA;
            end
            WR_GOT_ADDR: if (w_hs)        wr_state_d = WR_COMMIT;
            WR_GOT_DATA: if (aw_hs)       wr_state_d = WR_COMMIT;
            WR_COMMIT:                    wr_state_d = WR_RESP;
            WR_RESP:     if (axil.bready) wr_state_d = WR_IDLE;
            default:                      wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs && ar_oor) begin
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = RD_RESP;
                end else if (ar_hs) begin
                    rd_addr_d  = axil.araddr[AXIL_ADDR_WIDTH-1:OFS];
                    rd_state_d = RD_REQ;
                end
            end
            RD_REQ: rd_state_d = RD_WAIT;
            RD_WAIT: begin
                if (rd_valid_i) begin
                    rdata_d    = rd_data_i;
                    rresp_d    = RESP_OKAY;
                    rd_state_d = RD_RESP;
                end
`ifdef VGA_AXIL_SLAVE_CTRL_RD_TIMEOUT_EN
                else if (rd_tmr_q == '0) begin
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = RD_RESP;
                end
`endif
            end
            RD_RESP: if (axil.rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_GOT_DATA);
        wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_GOT_ADDR);
        arready_d = (rd_state_d == RD_IDLE);
        wr_en_o   = (wr_state_q == WR_COMMIT) && !wr_err_q && (wr_strb_q != '0);
        rd_en_o   = (rd_state_q == RD_REQ);
    end

    assign axil.awready = awready_q;
    assign axil.wready  = wready_q;
    assign axil.arready = arready_q;
    assign axil.bvalid  = (wr_state_q == WR_RESP);
    assign axil.bresp   = (wr_state_q == WR_RESP && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axil.rvalid  = (rd_state_q == RD_RESP);
    assign axil.rdata   = rdata_q;
    assign axil.rresp   = rresp_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign wr_strb_o    = wr_strb_q;
    assign rd_addr_o    = rd_addr_q;
endmodule

// File: tb/tb_vga_axil_slave_ctrl.sv
// Scoreboard bench for vga_axil_slave_ctrl: native strobes and B/R responses checked against queued expectations.
`timescale 1ns/1ps
module tb_vga_axil_slave_ctrl;
    localparam int AW = 32, DW = 32, SW = 4, NAW = 30, NUM_WORDS = 1024;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef struct packed {
        logic [NAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
    } wr_exp_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } r_exp_t;

    logic           clk = 1'b0;
    logic           arst_n = 1'b1;
    logic           wr_en, rd_en, rd_valid;
    logic [NAW-1:0] wr_addr, rd_addr;
    logic [DW-1:0]  wr_data, rd_data;
    logic [SW-1:0]  wr_strb;
    int             checks = 0, errors = 0;

    wr_exp_t        exp_wr_q[$];
    logic [NAW-1:0] exp_rd_q[$];
    logic [1:0]     exp_b_q[$];
    r_exp_t         exp_r_q[$];

    vga_axil_slave_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) axil();

    vga_axil_slave_ctrl #(
        .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW), .NUM_WORDS(NUM_WORDS), .RD_TIMEOUT(16)
    ) dut (
        .clk(clk), .arst_n(arst_n), .axil(axil),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_strb_o(wr_strb),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data), .rd_valid_i(rd_valid)
    );

    always #5 clk = ~clk;

    // One clock; native strobes are scored at the falling edge against the expectation queues.
    task automatic tick();
        wr_exp_t        e;
        logic [NAW-1:0] a;
        @(negedge clk);
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_strobe_unexpected addr=%h data=%h strb=%h", wr_addr, wr_data, wr_strb);
            end else begin
                e = exp_wr_q.pop_front();
                if ({wr_addr, wr_data, wr_strb} !== e) begin
                    errors++;
                    $display("FAIL wr_strobe got addr=%h data=%h strb=%h required addr=%h data=%h strb=%h",
                             wr_addr, wr_data, wr_strb, e.addr, e.data, e.strb);
                end
            end
        end
        if (rd_en === 1'b1) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_strobe_unexpected addr=%h", rd_addr);
            end else begin
                a = exp_rd_q.pop_front();
                if (rd_addr !== a) begin
                    errors++;
                    $display("FAIL rd_strobe_addr got %h required %h", rd_addr, a);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_both(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n = 0;
        axil.awaddr = a; axil.awvalid = 1'b1;
        axil.wdata = d; axil.wstrb = s; axil.wvalid = 1'b1;
        while (!(axil.awready === 1'b1 && axil.wready === 1'b1) && n < 20) begin tick(); n++; end
        checks++;
        if (!(axil.awready === 1'b1 && axil.wready === 1'b1)) begin
            errors++;
            $display("FAIL aw_w_ready got %b%b required 11", axil.awready, axil.wready);
        end
        tick();
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    endtask

    task automatic wait_b(input int hold);
        int n = 0;
        logic [1:0] eb;
        while (axil.bvalid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (axil.bvalid !== 1'b1) begin
            errors++;
            $display("FAIL b_timeout bvalid=%b required 1", axil.bvalid);
            return;
        end
        eb = exp_b_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (axil.bvalid !== 1'b1 || axil.bresp !== eb || axil.awready !== 1'b0 || axil.wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold cyc=%0d got bvalid=%b bresp=%b awready=%b wready=%b required 1 %b 0 0",
                         i, axil.bvalid, axil.bresp, axil.awready, axil.wready, eb);
            end
            if (i < hold) tick();
        end
        axil.bready = 1'b1;
        tick();
        axil.bready = 1'b0;
        checks++;
        if (axil.bvalid !== 1'b0 || axil.awready !== 1'b1 || axil.wready !== 1'b1) begin
            errors++;
            $display("FAIL b_done got bvalid=%b awready=%b wready=%b required 0 1 1",
                     axil.bvalid, axil.awready, axil.wready);
        end
    endtask

    task automatic read_ar(input logic [AW-1:0] a);
        int n = 0;
        axil.araddr = a; axil.arvalid = 1'b1;
        while (axil.arready !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (axil.arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_ready got %b required 1", axil.arready);
        end
        tick();
        axil.arvalid = 1'b0;
    endtask

    task automatic wait_r(input int hold);
        int n = 0;
        r_exp_t er;
        while (axil.rvalid !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (axil.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL r_timeout rvalid=%b required 1", axil.rvalid);
            return;
        end
        er = exp_r_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (axil.rvalid !== 1'b1 || axil.rdata !== er.data || axil.rresp !== er.resp || axil.arready !== 1'b0) begin
                errors++;
                $display("FAIL r_hold cyc=%0d got rvalid=%b rdata=%h rresp=%b arready=%b required 1 %h %b 0",
                         i, axil.rvalid, axil.rdata, axil.rresp, axil.arready, er.data, er.resp);
            end
            if (i < hold) tick();
        end
        axil.rready = 1'b1;
        tick();
        axil.rready = 1'b0;
        checks++;
        if (axil.rvalid !== 1'b0 || axil.arready !== 1'b1) begin
            errors++;
            $display("FAIL r_done got rvalid=%b arready=%b required 0 1", axil.rvalid, axil.arready);
        end
    endtask

    task automatic test_reset();
        axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0;
        axil.bready = 1'b0; axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
        rd_data = '0; rd_valid = 1'b0;
        #1 arst_n = 1'b0;
        #1;
        checks++;
        if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid, wr_en, rd_en} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid, wr_en, rd_en});
        end
        tick(); tick();
        checks++;
        if ({axil.bresp, axil.rresp, axil.rdata, wr_addr, wr_data, wr_strb, rd_addr, axil.awready,
             axil.wready, axil.arready} !== '0) begin
            errors++;
            $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h wr_addr=%h wr_data=%h strb=%h rd_addr=%h rdy=%b%b%b required all 0",
                     axil.bresp, axil.rresp, axil.rdata, wr_addr, wr_data, wr_strb, rd_addr,
                     axil.awready, axil.wready, axil.arready);
        end
        arst_n = 1'b1;
        tick();
        checks++;
        if ({axil.awready, axil.wready, axil.arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 111", {axil.awready, axil.wready, axil.arready});
        end
    endtask

    task automatic test_write_same_cycle();
        exp_wr_q.push_back({30'd4, 32'hDEADBEEF, 4'hF});
        exp_b_q.push_back(OKAY);
        write_both(32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if ({axil.awready, axil.wready} !== 2'b00) begin
            errors++;
            $display("FAIL commit_ready got %b required 00", {axil.awready, axil.wready});
        end
        wait_b(0);
    endtask

    task automatic test_write_w_first();
        exp_wr_q.push_back({30'd2, 32'h00001234, 4'b0011});
        exp_b_q.push_back(OKAY);
        axil.wdata = 32'h1234; axil.wstrb = 4'b0011; axil.wvalid = 1'b1;
        tick();
        axil.wvalid = 1'b0;
        checks++;
        if ({axil.awready, axil.wready, axil.bvalid} !== 3'b100) begin
            errors++;
            $display("FAIL got_data_ready got %b required 100", {axil.awready, axil.wready, axil.bvalid});
        end
        tick(); tick();
        axil.awaddr = 32'h8; axil.awvalid = 1'b1;
        tick();
        axil.awvalid = 1'b0;
        wait_b(5);
    endtask

    task automatic test_read_latency();
        exp_rd_q.push_back(30'd8);
        exp_r_q.push_back({32'hA5A5A5A5, OKAY});
        read_ar(32'h20);
        checks++;
        if (rd_en !== 1'b1) begin
            errors++;
            $display("FAIL rd_en_latency got %b required 1", rd_en);
        end
        repeat (4) tick();
        checks++;
        if (axil.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_early got %b required 0", axil.rvalid);
        end
        rd_data = 32'hA5A5A5A5; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0; rd_data = '0;
        wait_r(3);
    endtask

    task automatic test_back_to_back();
        exp_rd_q.push_back(30'd3);
        exp_r_q.push_back({32'h0BADCAFE, OKAY});
        read_ar(32'hC);
        tick();
        rd_data = 32'h0BADCAFE; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0; rd_data = '0;
        checks++;
        if (axil.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rd_min_latency rvalid got %b required 1", axil.rvalid);
        end
        wait_r(0);
        exp_wr_q.push_back({30'd1023, 32'h77665544, 4'b1000});
        exp_b_q.push_back(OKAY);
        write_both((NUM_WORDS - 1) * 4, 32'h77665544, 4'b1000);
        wait_b(1);
    endtask

    task automatic test_out_of_range();
        exp_r_q.push_back({32'h0, SLVERR});
        read_ar(NUM_WORDS * 4);
        wait_r(2);
        exp_b_q.push_back(SLVERR);
        write_both(NUM_WORDS * 4, 32'hFFFF0000, 4'hF);
        wait_b(0);
        exp_b_q.push_back(OKAY);
        write_both(32'h4, 32'h13572468, 4'h0);
        wait_b(0);
    endtask

    task automatic test_reset_mid();
        exp_rd_q.push_back(30'd5);
        exp_wr_q.push_back({30'd6, 32'hCAFEF00D, 4'hF});
        axil.araddr = 32'h14; axil.arvalid = 1'b1;
        axil.awaddr = 32'h18; axil.awvalid = 1'b1;
        axil.wdata = 32'hCAFEF00D; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        tick();
        axil.arvalid = 1'b0; axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        checks++;
        if ({wr_en, rd_en} !== 2'b11) begin
            errors++;
            $display("FAIL concurrent_strobes got %b required 11", {wr_en, rd_en});
        end
        tick();
        checks++;
        if ({axil.bvalid, axil.rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_valid got %b required 10", {axil.bvalid, axil.rvalid});
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid, wr_en, rd_en, axil.bresp,
             axil.rresp, axil.rdata, wr_addr, wr_data, wr_strb, rd_addr} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got rdy=%b%b%b bv=%b rv=%b rd_addr=%h wr_addr=%h wr_data=%h required all 0",
                     axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid, rd_addr, wr_addr, wr_data);
        end
        tick(); tick();
        arst_n = 1'b1;
        tick();
        checks++;
        if ({axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL post_reset_ready got %b required 11100",
                     {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid});
        end
        exp_rd_q.push_back(30'd16);
        exp_r_q.push_back({32'h600DF00D, OKAY});
        read_ar(32'h40);
        tick();
        rd_data = 32'h600DF00D; rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0; rd_data = '0;
        wait_r(0);
    endtask

`ifdef VGA_AXIL_SLAVE_CTRL_RD_TIMEOUT_EN
    task automatic test_rd_timeout();
        exp_rd_q.push_back(30'd1);
        exp_r_q.push_back({32'h0, SLVERR});
        read_ar(32'h4);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) begin
                checks++;
                if (axil.rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early rvalid got %b required 0", axil.rvalid);
                end
            end
        end
        checks++;
        if (axil.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cycle rvalid got %b required 1", axil.rvalid);
        end
        wait_r(0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_same_cycle();
        test_write_w_first();
        test_read_latency();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef VGA_AXIL_SLAVE_CTRL_RD_TIMEOUT_EN
        test_rd_timeout();
`endif
        tick(); tick();
        checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes pending wr=%0d rd=%0d required 0 0", exp_wr_q.size(), exp_rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
